// File: rtl/jpu_pkg.sv
// jpu_pkg: shared definitions for the JPU decode stage.
//   - Field offset helpers derived from INSTR_W / REG_BITS. Fields are
//     packed MSB-first: opcode, rD, imm-flag, rA, rB. The immediate
//     occupies the low IMM_W bits.
//   - Opcode names and the default "does not write rD" mask.
//   - decoded_t: the width-independent control fields of a decoded word.
package jpu_pkg;

  localparam int OPCODE_W = 4;

  // Opcodes 14 and 15 are the ones that never write a destination register.
  localparam logic [15:0] DEFAULT_NOWRITE_MASK = 16'hC000;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_SHL    = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SHR    = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_MOV    = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'hF;

  function automatic int opcodeLsb(input int instrW);
    return instrW - OPCODE_W;
  endfunction

  function automatic int rdLsb(input int instrW, input int regBits);
    return instrW - OPCODE_W - regBits;
  endfunction

  function automatic int flagPos(input int instrW, input int regBits);
    return instrW - OPCODE_W - 1 - regBits;
  endfunction

  function automatic int raLsb(input int instrW, input int regBits);
    return instrW - OPCODE_W - 1 - 2 * regBits;
  endfunction

  function automatic int rbLsb(input int instrW, input int regBits);
    return instrW - OPCODE_W - 1 - 3 * regBits;
  endfunction

  // Control fields whose widths do not depend on the block parameters;
  // register selects and the immediate are carried alongside.
  typedef struct packed {
    logic [OPCODE_W-1:0] aluOp;
    logic                immFlag;
    logic                writeEnable;
  } decoded_t;

endpackage

// File: rtl/jpu_scoreboard.sv
// jpu_scoreboard: one pending bit per register plus the hazard compare.
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   en_i               pending register only updates while high
//   set_valid_i/reg_i  an issuing instruction will write set_reg_i
//   clr_valid_i/reg_i  a writeback retires clr_reg_i
//   held_valid_i/reg_i output register holds a writer of held_reg_i
//   reads_src_i        incoming word reads src_a_i and src_b_i
//   writes_dst_i       incoming word writes dst_i
//   hazard_o           incoming word must stall
//   pending_o          pending vector
module jpu_scoreboard #(
  parameter int REG_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     set_valid_i,
  input  logic [REG_BITS-1:0]      set_reg_i,
  input  logic                     clr_valid_i,
  input  logic [REG_BITS-1:0]      clr_reg_i,
  input  logic                     held_valid_i,
  input  logic [REG_BITS-1:0]      held_reg_i,
  input  logic                     reads_src_i,
  input  logic [REG_BITS-1:0]      src_a_i,
  input  logic [REG_BITS-1:0]      src_b_i,
  input  logic                     writes_dst_i,
  input  logic [REG_BITS-1:0]      dst_i,
  output logic                     hazard_o,
  output logic [2**REG_BITS-1:0]   pending_o
);

  logic [2**REG_BITS-1:0] pending_q;
  logic [2**REG_BITS-1:0] pending_d;
  logic                   srcHit;
  logic                   dstHit;

  // Clear is applied before set so a same-cycle issue and retire of one
  // register leaves it pending: the new write is still outstanding.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) pending_d[clr_reg_i] = 1'b0;
    if (set_valid_i) pending_d[set_reg_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else if (en_i) pending_q <= pending_d;
  end

  // Compares use the registered vector only, so a writeback never
  // unblocks a stalled word in the cycle it retires.
  always_comb begin
    srcHit = reads_src_i &&
             (pending_q[src_a_i] || pending_q[src_b_i] ||
              (held_valid_i && (held_reg_i == src_a_i || held_reg_i == src_b_i)));
    dstHit = writes_dst_i &&
             (pending_q[dst_i] || (held_valid_i && held_reg_i == dst_i));
    hazard_o = srcHit || dstHit;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/jpu_decode_stage.sv
// jpu_decode_stage: pipelined instruction decoder with hazard scoreboard.
// Accepts words on in_valid_i/in_ready_o, splits them into fields, holds
// them in a one-deep output register (out_valid_o/out_ready_i) and stalls
// on RAW/WAW hazards against pending writes and the held output.
// Ports:
//   clk_i, rst_i, en_i, flush_i          control
//   in_valid_i, in_ready_o, instruction_i input handshake and word
//   out_valid_o, out_ready_i             output handshake
//   alu_op_o, imm_flag_o, imm_data_o,
//   rega_sel_o, regb_sel_o, regd_sel_o,
//   write_enable_o                       decoded fields
//   wb_valid_i, wb_reg_i                 writeback retire
//   pending_o                            scoreboard vector (debug)
module jpu_decode_stage
  import jpu_pkg::*;
#(
  parameter int          INSTR_W      = 16,
  parameter int          REG_BITS     = 3,
  parameter int          IMM_W        = 8,
  parameter logic [15:0] NOWRITE_MASK = DEFAULT_NOWRITE_MASK
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INSTR_W-1:0]     instruction_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [3:0]             alu_op_o,
  output logic                   imm_flag_o,
  output logic [IMM_W-1:0]       imm_data_o,
  output logic [REG_BITS-1:0]    rega_sel_o,
  output logic [REG_BITS-1:0]    regb_sel_o,
  output logic [REG_BITS-1:0]    regd_sel_o,
  output logic                   write_enable_o,
  input  logic                   wb_valid_i,
  input  logic [REG_BITS-1:0]    wb_reg_i,
  output logic [2**REG_BITS-1:0] pending_o
);

  localparam int OP_LSB   = opcodeLsb(INSTR_W);
  localparam int RD_LSB   = rdLsb(INSTR_W, REG_BITS);
  localparam int FLAG_POS = flagPos(INSTR_W, REG_BITS);
  localparam int RA_LSB   = raLsb(INSTR_W, REG_BITS);
  localparam int RB_LSB   = rbLsb(INSTR_W, REG_BITS);

  if (INSTR_W < 5 + 3 * REG_BITS) begin : gBadInstrW
    $error("jpu_decode_stage: INSTR_W too small for REG_BITS");
  end
  if (IMM_W > INSTR_W - 5 - REG_BITS) begin : gBadImmW
    $error("jpu_decode_stage: IMM_W overlaps opcode/rD/flag fields");
  end

  decoded_t              dec;
  logic [REG_BITS-1:0]   decRa, decRb, decRd;
  logic [IMM_W-1:0]      decImm;

  decoded_t              ctrl_q, ctrl_d;
  logic [REG_BITS-1:0]   regA_q, regA_d, regB_q, regB_d, regD_q, regD_d;
  logic [IMM_W-1:0]      imm_q, imm_d;
  logic                  outValid_q, outValid_d;

  logic                  hazard;
  logic                  inReady;
  logic                  accept;
  logic                  issue;

  // Field extraction from the incoming word.
  always_comb begin
    dec.aluOp       = instruction_i[OP_LSB +: OPCODE_W];
    dec.immFlag     = instruction_i[FLAG_POS];
    dec.writeEnable = ~NOWRITE_MASK[dec.aluOp];
    decRd           = instruction_i[RD_LSB +: REG_BITS];
    decRa           = instruction_i[RA_LSB +: REG_BITS];
    decRb           = instruction_i[RB_LSB +: REG_BITS];
    decImm          = instruction_i[IMM_W-1:0];
  end

  // in_ready is gated by rst so it stays low for the whole reset window.
  always_comb begin
    inReady = !rst_i && en_i && !flush_i && !hazard && (!outValid_q || out_ready_i);
    accept  = in_valid_i && inReady;
    issue   = outValid_q && out_ready_i && en_i && !flush_i;
  end

  // Output register next state: flush drops the word, accept loads a new
  // one (possibly in the same cycle the old one issues), issue alone empties.
  always_comb begin
    outValid_d = outValid_q;
    ctrl_d     = ctrl_q;
    regA_d     = regA_q;
    regB_d     = regB_q;
    regD_d     = regD_q;
    imm_d      = imm_q;
    if (en_i) begin
      if (flush_i) begin
        outValid_d = 1'b0;
      end else if (accept) begin
        outValid_d = 1'b1;
        ctrl_d     = dec;
        regA_d     = decRa;
        regB_d     = decRb;
        regD_d     = decRd;
        imm_d      = decImm;
      end else if (issue) begin
        outValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      ctrl_q     <= '0;
      regA_q     <= '0;
      regB_q     <= '0;
      regD_q     <= '0;
      imm_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      ctrl_q     <= ctrl_d;
      regA_q     <= regA_d;
      regB_q     <= regB_d;
      regD_q     <= regD_d;
      imm_q      <= imm_d;
    end
  end

  jpu_scoreboard #(
    .REG_BITS(REG_BITS)
  ) uScoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .set_valid_i (issue && ctrl_q.writeEnable),
    .set_reg_i   (regD_q),
    .clr_valid_i (wb_valid_i),
    .clr_reg_i   (wb_reg_i),
    .held_valid_i(outValid_q && ctrl_q.writeEnable),
    .held_reg_i  (regD_q),
    .reads_src_i (!dec.immFlag),
    .src_a_i     (decRa),
    .src_b_i     (decRb),
    .writes_dst_i(dec.writeEnable),
    .dst_i       (decRd),
    .hazard_o    (hazard),
    .pending_o   (pending_o)
  );

  assign in_ready_o     = inReady;
  assign out_valid_o    = outValid_q;
  assign alu_op_o       = ctrl_q.aluOp;
  assign imm_flag_o     = ctrl_q.immFlag;
  assign write_enable_o = ctrl_q.writeEnable;
  assign imm_data_o     = imm_q;
  assign rega_sel_o     = regA_q;
  assign regb_sel_o     = regB_q;
  assign regd_sel_o     = regD_q;

endmodule

// File: tb/tb_jpu_decode_stage.sv
module tb_jpu_decode_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        imm_flag;
  logic [7:0]  imm_data;
  logic [2:0]  rega_sel;
  logic [2:0]  regb_sel;
  logic [2:0]  regd_sel;
  logic        write_enable;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [7:0]  pending;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expQ[$];
  logic [31:0] expWord;

  jpu_decode_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .instruction_i (instruction),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .alu_op_o      (alu_op),
    .imm_flag_o    (imm_flag),
    .imm_data_o    (imm_data),
    .rega_sel_o    (rega_sel),
    .regb_sel_o    (regb_sel),
    .regd_sel_o    (regd_sel),
    .write_enable_o(write_enable),
    .wb_valid_i    (wb_valid),
    .wb_reg_i      (wb_reg),
    .pending_o     (pending)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference decode for the default field layout and no-write mask.
  function automatic logic [31:0] decodeModel(input logic [15:0] w);
    logic [15:0] mask;
    logic        we;
    mask = 16'hC000;
    we   = ~mask[w[15:12]];
    return {9'd0, w[15:12], w[8], w[7:0], w[7:5], w[4:2], w[11:9], we};
  endfunction

  function automatic logic [31:0] observedFields();
    return {9'd0, alu_op, imm_flag, imm_data, rega_sel, regb_sel, regd_sel, write_enable};
  endfunction

  task automatic applyStimulus(input logic [15:0] word, input logic valid);
    instruction = word;
    in_valid    = valid;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: accepted words are pushed with their expected fields and
  // compared when the stage hands them to execute; a flush discards them.
  always @(negedge clk) begin
    if (!rst) begin
      if (en && flush && out_valid) begin
        if (expQ.size() > 0) expWord = expQ.pop_front();
      end else if (en && out_valid && out_ready) begin
        checkOutput("queueDepthAtIssue", 32'(expQ.size()), 1);
        if (expQ.size() > 0) begin
          expWord = expQ.pop_front();
          checkOutput("issuedFields", observedFields(), expWord);
        end
      end
      if (in_valid && in_ready) expQ.push_back(decodeModel(instruction));
    end
  end

  initial begin
    clk = 0; rst = 1; en = 1; flush = 0; in_valid = 0; instruction = 16'h0000;
    out_ready = 1; wb_valid = 0; wb_reg = 3'd0;

    // Reset state
    #1;
    checkOutput("resetOutValid", 32'(out_valid), 0);
    checkOutput("resetPending", 32'(pending), 0);
    checkOutput("resetInReady", 32'(in_ready), 0);
    checkOutput("resetAluOp", 32'(alu_op), 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1 checkOutput("readyAfterReset", 32'(in_ready), 1);

    // Field decode
    out_ready = 0;
    applyStimulus(16'h3412, 1);
    nextCycle();
    in_valid = 0;
    #1;
    checkOutput("decodeValid", 32'(out_valid), 1);
    checkOutput("decodeAluOp", 32'(alu_op), 3);
    checkOutput("decodeRegD", 32'(regd_sel), 2);
    checkOutput("decodeFlag", 32'(imm_flag), 0);
    checkOutput("decodeRegA", 32'(rega_sel), 0);
    checkOutput("decodeRegB", 32'(regb_sel), 4);
    checkOutput("decodeImm", 32'(imm_data), 32'h12);
    checkOutput("decodeWe", 32'(write_enable), 1);
    out_ready = 1;
    nextCycle();
    #1;
    checkOutput("issueEmpties", 32'(out_valid), 0);
    checkOutput("issueSetsPending", 32'(pending), 32'h04);

    // RAW stall on r2
    applyStimulus(16'h1040, 1);
    #1 checkOutput("rawStall", 32'(in_ready), 0);
    nextCycle();
    #1;
    checkOutput("rawStillStalled", 32'(in_ready), 0);
    checkOutput("rawNoOutput", 32'(out_valid), 0);
    wb_valid = 1; wb_reg = 3'd2;
    #1 checkOutput("noBypass", 32'(in_ready), 0);
    nextCycle();
    wb_valid = 0;
    #1;
    checkOutput("wbClears", 32'(pending), 0);
    checkOutput("rawRelease", 32'(in_ready), 1);
    nextCycle();
    in_valid = 0;
    #1;
    checkOutput("rawAcceptedValid", 32'(out_valid), 1);
    checkOutput("rawAcceptedAluOp", 32'(alu_op), 1);
    checkOutput("rawAcceptedRegA", 32'(rega_sel), 2);
    nextCycle();
    #1 checkOutput("r0Pending", 32'(pending), 32'h01);
    wb_valid = 1; wb_reg = 3'd0;
    nextCycle();
    wb_valid = 0;
    #1 checkOutput("r0Retired", 32'(pending), 0);

    // No-write opcode
    applyStimulus(16'hF342, 1);
    nextCycle();
    in_valid = 0;
    #1;
    checkOutput("nowriteAluOp", 32'(alu_op), 32'hF);
    checkOutput("nowriteRegD", 32'(regd_sel), 1);
    checkOutput("nowriteFlag", 32'(imm_flag), 1);
    checkOutput("nowriteRegA", 32'(rega_sel), 2);
    checkOutput("nowriteImm", 32'(imm_data), 32'h42);
    checkOutput("nowriteWe", 32'(write_enable), 0);
    nextCycle();
    #1;
    checkOutput("nowriteIssued", 32'(out_valid), 0);
    checkOutput("nowritePending", 32'(pending), 0);

    // Backpressure
    out_ready = 0;
    applyStimulus(16'h7801, 1);
    nextCycle();
    applyStimulus(16'hF342, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("holdValid", 32'(out_valid), 1);
      checkOutput("holdAluOp", 32'(alu_op), 7);
      checkOutput("holdRegD", 32'(regd_sel), 4);
      checkOutput("holdImm", 32'(imm_data), 32'h01);
      checkOutput("holdInReady", 32'(in_ready), 0);
      nextCycle();
    end
    out_ready = 1;
    #1 checkOutput("readyFollowsOutReady", 32'(in_ready), 1);
    nextCycle();
    #1;
    checkOutput("releaseSetsR4", 32'(pending), 32'h10);
    checkOutput("releaseEmpties", 32'(out_valid), 0);
    wb_valid = 1; wb_reg = 3'd4;
    nextCycle();
    wb_valid = 0;
    #1 checkOutput("r4Retired", 32'(pending), 0);

    // Flush
    out_ready = 0;
    applyStimulus(16'h7801, 1);
    nextCycle();
    in_valid = 0;
    #1 checkOutput("flushHeld", 32'(out_valid), 1);
    flush = 1;
    applyStimulus(16'hF342, 1);
    #1 checkOutput("flushBlocksAccept", 32'(in_ready), 0);
    nextCycle();
    flush = 0; in_valid = 0;
    #1;
    checkOutput("flushClearsValid", 32'(out_valid), 0);
    checkOutput("flushNoPending", 32'(pending), 0);
    out_ready = 1;
    nextCycle();
    #1;
    checkOutput("flushedWordGone", 32'(out_valid), 0);
    checkOutput("flushStillNoPending", 32'(pending), 0);

    // Same-cycle issue and retire of r4
    out_ready = 0;
    applyStimulus(16'h7801, 1);
    nextCycle();
    in_valid = 0; out_ready = 1; wb_valid = 1; wb_reg = 3'd4;
    nextCycle();
    wb_valid = 0;
    #1 checkOutput("setWinsOverClear", 32'(pending), 32'h10);

    // Enable low holds the scoreboard and blocks acceptance
    en = 0; wb_valid = 1; wb_reg = 3'd4;
    applyStimulus(16'hF342, 1);
    #1 checkOutput("enLowNotReady", 32'(in_ready), 0);
    nextCycle();
    #1;
    checkOutput("enLowHoldsPending", 32'(pending), 32'h10);
    checkOutput("enLowNoAccept", 32'(out_valid), 0);
    in_valid = 0; en = 1;
    nextCycle();
    wb_valid = 0;
    #1 checkOutput("enHighRetires", 32'(pending), 0);

    // Reset in the middle of a stall
    applyStimulus(16'h7801, 1);
    nextCycle();
    in_valid = 0;
    nextCycle();
    #1 checkOutput("preResetPending", 32'(pending), 32'h10);
    out_ready = 0;
    applyStimulus(16'hF342, 1);
    nextCycle();
    applyStimulus(16'h7801, 1);
    #1 checkOutput("stallBeforeReset", 32'(in_ready), 0);
    #1 rst = 1;
    #1;
    checkOutput("asyncResetValid", 32'(out_valid), 0);
    checkOutput("asyncResetFields", observedFields(), 0);
    checkOutput("asyncResetPending", 32'(pending), 0);
    checkOutput("asyncResetInReady", 32'(in_ready), 0);
    expQ.delete();
    in_valid = 0;
    nextCycle();
    rst = 0;
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
